// File: rtl/regfile_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_alu_seq
// Purpose  : Parametrised register file with registered reads, a sequenced
//            IDLE/EXEC/WB execute engine, an ALU with status flags, an
//            optional hardwired zero register and a sliced 16-bit LED view
//            of read port A. Buttons are edge-detected internally.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_alu_seq #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [15:0]                                         sw,
  input  logic                                                btnl,
  input  logic                                                btnc,
  input  logic [((XLEN/16) > 1 ? $clog2(XLEN/16) : 1)-1:0]    led_sel,
  output logic [15:0]                                         led,
  output logic                                                busy,
  output logic                                                flag_z,
  output logic                                                flag_v
);

  localparam int AW     = $clog2(NREGS);
  localparam int SHW    = $clog2(XLEN);
  localparam int NSLICE = XLEN / 16;
  localparam int LSW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam bit ZR_EN  = (ZERO_REG != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1101;

  // Button edge detection
  logic btnl_dly_q, btnl_dly_d, btnl_os_q, btnl_os_d;
  logic btnc_dly_q, btnc_dly_d, btnc_os_q, btnc_os_d;

  // Control state, address fields and captured command
  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [15:0]     cmd_q, cmd_d;

  // Datapath
  logic [XLEN-1:0] result_q, result_d;
  logic            res_v_q, res_v_d;
  logic [XLEN-1:0] read_a_q, read_a_d, read_b_q, read_b_d;
  logic            flag_z_q, flag_z_d, flag_v_q, flag_v_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Combinational helpers
  logic [XLEN-1:0] alu_res;
  logic            alu_v;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] sum_ab, diff_ab;
  logic [SHW-1:0]  sh_amt;
  logic            wr_en;

  // A single-cycle pulse on the cycle after a button is first sampled high
  always_comb begin
    btnl_dly_d = btnl;
    btnc_dly_d = btnc;
    btnl_os_d  = btnl & ~btnl_dly_q;
    btnc_os_d  = btnc & ~btnc_dly_q;
  end

  // Sequencer: execute beats address load when both pulses coincide in IDLE
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    case (state_q)
      ST_IDLE: begin
        if (btnc_os_q) begin
          state_d = ST_EXEC;
          cmd_d   = sw;
        end else if (btnl_os_q) begin
          rd_d  = sw[10 +: AW];
          rs2_d = sw[5 +: AW];
          rs1_d = sw[0 +: AW];
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU on the registered read ports; unknown opcodes fall back to ADD
  always_comb begin
    sum_ab  = read_a_q + read_b_q;
    diff_ab = read_a_q - read_b_q;
    sh_amt  = read_b_q[SHW-1:0];
    alu_res = sum_ab;
    alu_v   = (read_a_q[XLEN-1] == read_b_q[XLEN-1]) &&
              (sum_ab[XLEN-1] != read_a_q[XLEN-1]);
    case (cmd_q[3:0])
      OP_AND: begin alu_res = read_a_q & read_b_q; alu_v = 1'b0; end
      OP_OR:  begin alu_res = read_a_q | read_b_q; alu_v = 1'b0; end
      OP_XOR: begin alu_res = read_a_q ^ read_b_q; alu_v = 1'b0; end
      OP_SUB: begin
        alu_res = diff_ab;
        alu_v   = (read_a_q[XLEN-1] != read_b_q[XLEN-1]) &&
                  (diff_ab[XLEN-1] != read_a_q[XLEN-1]);
      end
      OP_SLT: begin
        alu_res = {{(XLEN-1){1'b0}}, ($signed(read_a_q) < $signed(read_b_q))};
        alu_v   = 1'b0;
      end
      OP_SLTU: begin
        alu_res = {{(XLEN-1){1'b0}}, (read_a_q < read_b_q)};
        alu_v   = 1'b0;
      end
      OP_SRL: begin alu_res = read_a_q >> sh_amt; alu_v = 1'b0; end
      OP_SLL: begin alu_res = read_a_q << sh_amt; alu_v = 1'b0; end
      OP_SRA: begin alu_res = $unsigned($signed(read_a_q) >>> sh_amt); alu_v = 1'b0; end
      default: ; // ADD and every unassigned code
    endcase
  end

  // Result capture at the end of EXEC: immediate or ALU output
  always_comb begin
    imm_ext  = {{(XLEN-15){cmd_q[14]}}, cmd_q[14:0]};
    result_d = result_q;
    res_v_d  = res_v_q;
    if (state_q == ST_EXEC) begin
      if (cmd_q[15]) begin
        result_d = imm_ext;
        res_v_d  = 1'b0;
      end else begin
        result_d = alu_res;
        res_v_d  = alu_v;
      end
    end
  end

  // Writeback, flag update and read ports with same-cycle forwarding
  always_comb begin
    wr_en    = (state_q == ST_WB) && !(ZR_EN && (rd_q == '0));
    regs_d   = regs_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    if (wr_en) begin
      regs_d[rd_q] = result_q;
      flag_z_d     = (result_q == '0);
      flag_v_d     = res_v_q;
    end
    read_a_d = (ZR_EN && (rs1_q == '0)) ? '0 : regs_q[rs1_q];
    read_b_d = (ZR_EN && (rs2_q == '0)) ? '0 : regs_q[rs2_q];
    if (wr_en && (rs1_q == rd_q)) read_a_d = result_q;
    if (wr_en && (rs2_q == rd_q)) read_b_d = result_q;
  end

  // All state flops; button delay flops reset high to mask a held button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnl_dly_q <= 1'b1;
      btnc_dly_q <= 1'b1;
      btnl_os_q  <= 1'b0;
      btnc_os_q  <= 1'b0;
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      result_q   <= '0;
      res_v_q    <= 1'b0;
      read_a_q   <= '0;
      read_b_q   <= '0;
      flag_z_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      btnl_dly_q <= btnl_dly_d;
      btnc_dly_q <= btnc_dly_d;
      btnl_os_q  <= btnl_os_d;
      btnc_os_q  <= btnc_os_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      result_q   <= result_d;
      res_v_q    <= res_v_d;
      read_a_q   <= read_a_d;
      read_b_q   <= read_b_d;
      flag_z_q   <= flag_z_d;
      flag_v_q   <= flag_v_d;
      regs_q     <= regs_d;
    end
  end

  // LED window onto read port A; out-of-range selects fall back to slice 0
  generate
    if (NSLICE > 1) begin : g_led_multi
      always_comb begin
        led = read_a_q[15:0];
        for (int s = 1; s < NSLICE; s++) begin
          if (led_sel == LSW'(s)) led = read_a_q[16*s +: 16];
        end
      end
    end else begin : g_led_single
      logic unused_sel;
      assign unused_sel = |led_sel;
      assign led        = read_a_q[15:0];
    end
  endgenerate

  assign busy   = (state_q != ST_IDLE);
  assign flag_z = flag_z_q;
  assign flag_v = flag_v_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_alu_seq
// Purpose  : Directed bench for regfile_alu_seq; a 32-bit/32-register and a
//            64-bit/8-register instance share all stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic        btnl, btnc;
  logic [1:0]  led_sel;
  logic [15:0] led32, led64;
  logic        busy32, busy64, fz32, fz64, fv32, fv64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_alu_seq #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btnl(btnl), .btnc(btnc),
    .led_sel(led_sel[0]), .led(led32), .busy(busy32),
    .flag_z(fz32), .flag_v(fv32)
  );

  regfile_alu_seq #(.XLEN(64), .NREGS(8), .ZERO_REG(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btnl(btnl), .btnc(btnc),
    .led_sel(led_sel), .led(led64), .busy(busy64),
    .flag_z(fz64), .flag_v(fv64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] exp);
    led_sel = 2'd0; #1;
    chk({tag, "_lo"}, 64'(led32), 64'(exp[15:0]));
    led_sel = 2'd1; #1;
    chk({tag, "_hi"}, 64'(led32), 64'(exp[31:16]));
    led_sel = 2'd0;
  endtask

  task automatic check64(input string tag, input logic [63:0] exp);
    for (int s = 0; s < 4; s++) begin
      led_sel = 2'(s); #1;
      chk($sformatf("%s_s%0d", tag, s), 64'(led64), 64'(exp[16*s +: 16]));
    end
    led_sel = 2'd0;
  endtask

  task automatic load_addr(input logic [15:0] v);
    sw = v; btnl = 1'b1;
    tick(); tick();
    btnl = 1'b0;
    tick(); tick();
  endtask

  task automatic exec_cmd(input logic [15:0] cmd);
    int n;
    sw = cmd; btnc = 1'b1;
    tick(); tick();
    btnc = 1'b0;
    n = 0;
    while (busy32 && n < 8) begin tick(); n++; end
    chk("exec_done", 64'(busy32), 64'd0);
    tick(); tick();
  endtask

  task automatic do_op(input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [15:0] cmd);
    load_addr({1'b0, rd, rs2, rs1});
    exec_cmd(cmd);
    load_addr({1'b0, rd, rs2, rd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sw = '0; btnl = 1'b0; btnc = 1'b0; led_sel = 2'd0;
    repeat (3) tick();
    // Reset state
    check32("rst_led", 32'h0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_busy64", 64'(busy64), 64'd0);
    chk("rst_fz", 64'(fz32), 64'd0);
    chk("rst_fv", 64'(fv32), 64'd0);
    rst_n = 1'b1;
    tick();

    // Writing zero to R0 is suppressed: flags stay clear, R0 still reads 0
    exec_cmd(16'h8000);
    chk("r0_fz_kept", 64'(fz32), 64'd0);
    check32("r0_write", 32'h0);

    // Immediates R[i] = 0x0101*i
    for (int i = 1; i < 32; i++) begin
      load_addr(16'((i << 10) | i));
      exec_cmd(16'h8000 | 16'(i * 32'h101));
      check32($sformatf("imm_r%0d", i), 32'(i) * 32'h101);
    end
    chk("imm_fz", 64'(fz32), 64'd0);
    load_addr(16'h0000);
    check32("r0_read", 32'h0);

    // Sign-extended -1, XOR, SUB
    do_op(5'd1, 5'd1, 5'd0, 16'hFFFF);
    check32("imm_m1", 32'hFFFF_FFFF);
    do_op(5'd2, 5'd1, 5'd2, 16'h000D);
    check32("xor", 32'hFFFF_FDFD);
    chk("xor_fz", 64'(fz32), 64'd0);
    do_op(5'd3, 5'd3, 5'd3, 16'h0006);
    check32("sub_zero", 32'h0);
    chk("sub_fz", 64'(fz32), 64'd1);
    chk("sub_fv", 64'(fv32), 64'd0);

    // Overflow, compares, shifts, logic, default op
    do_op(5'd6, 5'd6, 5'd0, 16'h8001);
    check32("r6_one", 32'h1);
    do_op(5'd4, 5'd1, 5'd6, 16'h0008);
    check32("srl1", 32'h7FFF_FFFF);
    do_op(5'd4, 5'd4, 5'd6, 16'h0002);
    check32("add_ovf", 32'h8000_0000);
    chk("add_fv", 64'(fv32), 64'd1);
    chk("add_fz", 64'(fz32), 64'd0);
    do_op(5'd7, 5'd4, 5'd6, 16'h0007);
    check32("slt_neg", 32'h1);
    chk("slt_fv_clr", 64'(fv32), 64'd0);
    do_op(5'd8, 5'd6, 5'd1, 16'h0003);
    check32("sltu_1", 32'h1);
    do_op(5'd9, 5'd1, 5'd6, 16'h0003);
    check32("sltu_0", 32'h0);
    chk("sltu_fz", 64'(fz32), 64'd1);
    do_op(5'd10, 5'd1, 5'd6, 16'h0007);
    check32("slt_m1", 32'h1);
    do_op(5'd11, 5'd4, 5'd6, 16'h0006);
    check32("sub_ovf", 32'h7FFF_FFFF);
    chk("sub_fv", 64'(fv32), 64'd1);
    do_op(5'd12, 5'd12, 5'd0, 16'hC000);
    check32("imm_neg", 32'hFFFF_C000);
    chk("imm_fv_clr", 64'(fv32), 64'd0);
    do_op(5'd13, 5'd6, 5'd31, 16'h0009);
    check32("sll31", 32'h8000_0000);
    do_op(5'd14, 5'd4, 5'd6, 16'h000A);
    check32("sra1", 32'hC000_0000);
    do_op(5'd15, 5'd2, 5'd12, 16'h0000);
    check32("and", 32'hFFFF_C000);
    do_op(5'd16, 5'd6, 5'd13, 16'h0001);
    check32("or", 32'h8000_0001);
    do_op(5'd17, 5'd6, 5'd6, 16'h0004);
    check32("dflt_add", 32'h2);

    // Button held through reset release produces no event
    btnc = 1'b1; rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("held_busy", 64'(busy32), 64'd0);
    end
    btnc = 1'b0; tick();
    load_addr(16'h0001);
    check32("rst_cleared", 32'h0);

    // Second execute pulse while busy is dropped
    do_op(5'd6, 5'd6, 5'd0, 16'h8001);
    do_op(5'd5, 5'd5, 5'd0, 16'h8010);
    load_addr({1'b0, 5'd5, 5'd6, 5'd5});
    sw = 16'h0002; btnc = 1'b1;
    tick();
    btnc = 1'b0;
    tick();
    chk("dbl_busy_hi", 64'(busy32), 64'd1);
    btnc = 1'b1;
    tick(); tick();
    btnc = 1'b0;
    repeat (6) tick();
    chk("dbl_busy_lo", 64'(busy32), 64'd0);
    check32("dbl_once", 32'h11);

    // Simultaneous load and execute: execute uses old addresses, load dropped
    sw = 16'h0002; btnl = 1'b1; btnc = 1'b1;
    tick(); tick();
    btnl = 1'b0; btnc = 1'b0;
    repeat (6) tick();
    chk("both_busy_lo", 64'(busy32), 64'd0);
    check32("both_old_addr", 32'h12);

    // 64-bit instance: shifts and LED slices
    do_op(5'd1, 5'd1, 5'd0, 16'hFFFF);
    check64("w64_m1", 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(5'd2, 5'd2, 5'd0, 16'h8004);
    do_op(5'd3, 5'd3, 5'd0, 16'h803C);
    do_op(5'd4, 5'd1, 5'd2, 16'h000A);
    check64("w64_sra4", 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(5'd5, 5'd1, 5'd3, 16'h0008);
    check64("w64_srl60", 64'h0000_0000_0000_000F);
    do_op(5'd6, 5'd1, 5'd2, 16'h0009);
    check64("w64_sll4", 64'hFFFF_FFFF_FFFF_FFF0);
    do_op(5'd7, 5'd1, 5'd2, 16'h0008);
    check64("w64_srl4", 64'h0FFF_FFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
